// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate truth-table checker.
// Holds the FSM encoding, the vector-count helper and common 2-input truth tables.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit k of a truth table is the expected gate output for input vector k.
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;

  function automatic int vec_count(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that sets how long each input vector dwells before sampling.
// zero is high while the count is 0; dec has no effect once zero.
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_value;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps every input vector of an N_IN-input gate, samples its output after a settle
// time and compares it against TRUTH, reporting pass, error count and first failing vector.
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int                    N_IN       = 2,
  parameter logic [(1<<N_IN)-1:0]  TRUTH      = TT_AND2,
  parameter int                    SETTLE_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec,
  output logic [1:0]      dbg_state
);

  localparam int              NV       = vec_count(N_IN);
  localparam logic [N_IN:0]   LAST_VEC = NV[N_IN:0] - 1'b1;
  localparam int              CW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE_CYC - 1);

  state_t            r_state;
  state_t            w_next;
  logic [N_IN:0]     r_vec;
  logic [N_IN:0]     r_err;
  logic              r_done;
  logic              r_pass;
  logic              r_ffv;
  logic [N_IN-1:0]   r_ffvec;

  logic              w_start_ok;
  logic              w_last;
  logic              w_mismatch;
  logic              w_load;
  logic              w_dec;
  logic              w_zero;

  // start is a level, accepted only at an edge where the FSM is IDLE or DONE;
  // while busy it is ignored and must be reissued once done is high.
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last     = (r_vec == LAST_VEC);
  assign w_mismatch = (r_state == CHECK) && (dut_out != TRUTH[r_vec[N_IN-1:0]]);

  assign w_load = w_start_ok || ((r_state == CHECK) && !w_last);
  assign w_dec  = (r_state == APPLY) && !w_zero;

  settle_timer #(
    .W (CW)
  ) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_load),
    .load_value (SETTLE_LOAD),
    .dec        (w_dec),
    .zero       (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_next = APPLY;
      APPLY:      if (w_zero) w_next = CHECK;
      CHECK:      w_next = w_last ? DONE : APPLY;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec   <= '0;
      r_err   <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_ffv   <= 1'b0;
      r_ffvec <= '0;
    end else if (w_start_ok) begin
      r_vec   <= '0;
      r_err   <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_ffv   <= 1'b0;
      r_ffvec <= '0;
    end else if (r_state == CHECK) begin
      if (w_mismatch) begin
        r_err <= r_err + 1'b1;
        if (!r_ffv) begin
          r_ffv   <= 1'b1;
          r_ffvec <= r_vec[N_IN-1:0];
        end
      end
      // pass must include this final vector's result, not just the registered count.
      if (w_last) begin
        r_done <= 1'b1;
        r_pass <= (r_err == '0) && !w_mismatch;
      end else begin
        r_vec <= r_vec + 1'b1;
      end
    end
  end

  assign busy             = (r_state == APPLY) || (r_state == CHECK);
  assign dut_in           = busy ? r_vec[N_IN-1:0] : '0;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign first_fail_valid = r_ffv;
  assign first_fail_vec   = r_ffvec;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: three parameterisations driven by an emulated gate
// whose truth table the bench chooses, with table-driven and randomized sweeps.
module tb_gate_truth_checker;
  import gate_check_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r_start = 1'b0;
  logic [7:0] r_gate = 8'h00;
  int         sel = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  // ---------------- instances ----------------
  logic       a_start, a_out, a_busy, a_done, a_pass, a_ffv;
  logic [1:0] a_in, a_ffvec, a_state;
  logic [2:0] a_err;
  logic       b_start, b_out, b_busy, b_done, b_pass, b_ffv;
  logic [1:0] b_in, b_ffvec, b_state;
  logic [2:0] b_err;
  logic       c_start, c_out, c_busy, c_done, c_pass, c_ffv;
  logic [2:0] c_in, c_ffvec;
  logic [1:0] c_state;
  logic [3:0] c_err;

  assign a_start = r_start && (sel == 0);
  assign b_start = r_start && (sel == 1);
  assign c_start = r_start && (sel == 2);
  assign a_out   = r_gate[{1'b0, a_in}];
  assign b_out   = r_gate[{1'b0, b_in}];
  assign c_out   = r_gate[c_in];

  gate_truth_checker u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .dut_in(a_in), .dut_out(a_out),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
    .first_fail_valid(a_ffv), .first_fail_vec(a_ffvec), .dbg_state(a_state)
  );

  gate_truth_checker #(.N_IN(2), .TRUTH(TT_AND2), .SETTLE_CYC(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .dut_in(b_in), .dut_out(b_out),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
    .first_fail_valid(b_ffv), .first_fail_vec(b_ffvec), .dbg_state(b_state)
  );

  gate_truth_checker #(.N_IN(3), .TRUTH(8'h96), .SETTLE_CYC(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .dut_in(c_in), .dut_out(c_out),
    .busy(c_busy), .done(c_done), .pass(c_pass), .err_count(c_err),
    .first_fail_valid(c_ffv), .first_fail_vec(c_ffvec), .dbg_state(c_state)
  );

  // Outputs of the selected instance, zero-extended to common widths.
  int w_busy, w_done, w_pass, w_ffv, w_ffvec, w_in, w_err, w_state;
  always_comb begin
    w_busy = 0; w_done = 0; w_pass = 0; w_ffv = 0;
    w_ffvec = 0; w_in = 0; w_err = 0; w_state = 0;
    case (sel)
      0: begin
        w_busy = int'(a_busy); w_done = int'(a_done); w_pass = int'(a_pass);
        w_ffv = int'(a_ffv); w_ffvec = int'(a_ffvec); w_in = int'(a_in);
        w_err = int'(a_err); w_state = int'(a_state);
      end
      1: begin
        w_busy = int'(b_busy); w_done = int'(b_done); w_pass = int'(b_pass);
        w_ffv = int'(b_ffv); w_ffvec = int'(b_ffvec); w_in = int'(b_in);
        w_err = int'(b_err); w_state = int'(b_state);
      end
      default: begin
        w_busy = int'(c_busy); w_done = int'(c_done); w_pass = int'(c_pass);
        w_ffv = int'(c_ffv); w_ffvec = int'(c_ffvec); w_in = int'(c_in);
        w_err = int'(c_err); w_state = int'(c_state);
      end
    endcase
  end

  // ---------------- helpers ----------------
  function automatic logic [7:0] tt_of(input int s);
    return (s == 2) ? 8'h96 : {4'h0, TT_AND2};
  endfunction
  function automatic int nin_of(input int s);
    return (s == 2) ? 3 : 2;
  endfunction
  function automatic int settle_of(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 3 : 2);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t sel=%0d)", name, act, exp, $time, sel);
  endtask

  // Reference: count the vectors where the emulated gate disagrees with the table.
  task automatic model(input int s, input logic [7:0] gtt,
                       output int e_err, output int e_ffv, output int e_ffvec, output int e_pass);
    logic [7:0] tt;
    tt = tt_of(s);
    e_err = 0; e_ffv = 0; e_ffvec = 0;
    for (int v = 0; v < (1 << nin_of(s)); v++) begin
      if (gtt[v[2:0]] != tt[v[2:0]]) begin
        if (e_err == 0) begin
          e_ffv = 1;
          e_ffvec = v;
        end
        e_err++;
      end
    end
    e_pass = (e_err == 0) ? 1 : 0;
  endtask

  // One full sweep; inject >= 0 raises start for one cycle at that sweep cycle.
  task automatic run_sweep(input int s, input logic [7:0] gtt, input int inject,
                           input int e_err, input int e_ffv, input int e_ffvec, input int e_pass);
    int sc, len;
    sel = s;
    r_gate = gtt;
    sc = settle_of(s) + 1;
    len = (1 << nin_of(s)) * sc;
    @(negedge clk);
    r_start = 1'b1;
    @(negedge clk);
    check("clear_err", w_err, 0);
    check("clear_ffv", w_ffv, 0);
    check("clear_ffvec", w_ffvec, 0);
    check("clear_done", w_done, 0);
    check("clear_pass", w_pass, 0);
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      check("busy_high", w_busy, 1);
      check("done_low", w_done, 0);
      check("dut_in_seq", w_in, k / sc);
      r_start = (k == inject);
    end
    @(negedge clk);
    r_start = 1'b0;
    check("done_rise", w_done, 1);
    check("busy_low", w_busy, 0);
    check("dut_in_idle", w_in, 0);
    check("state_done", w_state, 3);
    check("err_count", w_err, e_err);
    check("ff_valid", w_ffv, e_ffv);
    check("ff_vec", w_ffvec, e_ffvec);
    check("pass", w_pass, e_pass);
    @(negedge clk);
    check("done_hold", w_done, 1);
    check("err_hold", w_err, e_err);
    check("pass_hold", w_pass, e_pass);
  endtask

  typedef struct {
    logic [7:0] gate;
    int         inject;
    int         err;
    int         ffv;
    int         ffvec;
    int         pass;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int e_err, e_ffv, e_ffvec, e_pass, s, inj;
    logic [7:0] g;

    // Instance A: TRUTH = AND2, expected results worked out by hand.
    tbl[0] = '{8'h08, -1, 0, 0, 0, 1};  // AND  matches
    tbl[1] = '{8'h0E,  3, 2, 1, 1, 0};  // OR   differs at 1,2
    tbl[2] = '{8'h00,  7, 1, 1, 3, 0};  // tied 0 differs at 3; start on last CHECK
    tbl[3] = '{8'h07, -1, 4, 1, 0, 0};  // NAND differs everywhere
    tbl[4] = '{8'h06, -1, 3, 1, 1, 0};  // XOR  differs at 1,2,3
    tbl[5] = '{8'h08, -1, 0, 0, 0, 1};  // AND again after an erroring sweep

    // Reset state, asserted from time 0.
    #12;
    check("rst_busy", w_busy, 0);
    check("rst_done", w_done, 0);
    check("rst_pass", w_pass, 0);
    check("rst_err", w_err, 0);
    check("rst_ffv", w_ffv, 0);
    check("rst_dut_in", w_in, 0);
    check("rst_state", w_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_state", w_state, 0);

    for (int i = 0; i < 6; i++)
      run_sweep(0, tbl[i].gate, tbl[i].inject, tbl[i].err, tbl[i].ffv, tbl[i].ffvec, tbl[i].pass);

    // SETTLE_CYC=3: 16-cycle sweep, start pulsed at cycle 5 is ignored.
    run_sweep(1, 8'h08, 5, 0, 0, 0, 1);

    // Asynchronous reset mid-sweep, after one mismatch has been recorded.
    sel = 0;
    r_gate = 8'h0E;
    @(negedge clk);
    r_start = 1'b1;
    @(negedge clk);
    r_start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_err_before_rst", w_err, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", w_busy, 0);
    check("arst_dut_in", w_in, 0);
    check("arst_err", w_err, 0);
    check("arst_ffv", w_ffv, 0);
    check("arst_ffvec", w_ffvec, 0);
    check("arst_state", w_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", w_state, 0);
    run_sweep(0, 8'h08, -1, 0, 0, 0, 1);

    // Randomized gates on all instances, checked against the reference model.
    for (int i = 0; i < 12; i++) begin
      s = int'($urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) g = tt_of(s);
      else g = 8'($urandom_range(0, 255));
      if (nin_of(s) == 2) g = g & 8'h0F;
      inj = int'($urandom_range(0, 30)) - 2;
      model(s, g, e_err, e_ffv, e_ffvec, e_pass);
      run_sweep(s, g, inj, e_err, e_ffv, e_ffvec, e_pass);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
